// File: rtl/print_string_unit_pkg.sv
// Shared CPU definitions used by the print-string syscall unit and the data memory.
package print_string_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EMIT,
        ST_FINISH,
        ST_FAULT
    } ps_state_t;

    // Data-memory word window, shared with the data memory's own range check.
    localparam logic [31:0] MEM_LO_ADDR = 32'h7FF0_0000;
    localparam logic [31:0] MEM_HI_ADDR = 32'h7FFF_FFFF;

    localparam logic [31:0] SYSCALL_PRINT_STRING = 32'd4;

    // Big-endian byte lane select: index 0 is the most significant byte.
    function automatic logic [7:0] unpack_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/print_string_unit.sv
// Print-string syscall engine: walks data memory downward from a word address and
// streams the packed bytes over a valid/ready channel until NUL, stalling the pipe meanwhile.
module print_string_unit
    import print_string_unit_pkg::*;
#(
    parameter logic [31:0] MEM_LO    = MEM_LO_ADDR,
    parameter logic [31:0] MEM_HI    = MEM_HI_ADDR,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_addr,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic        char_valid,
    output logic [7:0]  char_data,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int CNT_W = $clog2(MAX_WORDS + 1);

    ps_state_t        state;
    logic [31:0]      cur_addr;
    logic [31:0]      word_reg;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_cnt;

    logic [7:0] cur_byte;
    logic [7:0] nxt_byte;
    logic       fetch_bad;

    always_comb begin
        cur_byte  = unpack_byte(word_reg, byte_idx);
        nxt_byte  = unpack_byte(word_reg, byte_idx + 2'd1);
        fetch_bad = (cur_addr < MEM_LO) || (cur_addr > MEM_HI) ||
                    (word_cnt == CNT_W'(MAX_WORDS));
    end

    // mem_addr is loaded on entry to FETCH so the combinational memory read
    // is already valid during the FETCH cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            word_reg   <= '0;
            byte_idx   <= '0;
            word_cnt   <= '0;
            mem_addr   <= '0;
            char_valid <= 1'b0;
            char_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr <= start_addr;
                        mem_addr <= start_addr;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        state    <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fetch_bad) begin
                        error <= 1'b1;
                        state <= ST_FAULT;
                    end else begin
                        word_reg   <= mem_read_data;
                        byte_idx   <= 2'd0;
                        word_cnt   <= word_cnt + 1'b1;
                        char_valid <= (mem_read_data[31:24] != 8'h00);
                        char_data  <= mem_read_data[31:24];
                        state      <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (cur_byte == 8'h00) begin
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else if (char_ready) begin
                        if (byte_idx != 2'd3) begin
                            // Preload the next lane; a NUL lands as valid=0 and ends the string next cycle.
                            byte_idx   <= byte_idx + 2'd1;
                            char_valid <= (nxt_byte != 8'h00);
                            char_data  <= nxt_byte;
                        end else begin
                            char_valid <= 1'b0;
                            cur_addr   <= cur_addr - 32'd1;
                            mem_addr   <= cur_addr - 32'd1;
                            state      <= ST_FETCH;
                        end
                    end
                end
                ST_FINISH, ST_FAULT: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_print_string_unit.sv
// Bench for print_string_unit: directed vector table, hand-written corner sequences
// and randomized strings checked against a string-walking reference model.
module tb_print_string_unit;
    import print_string_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        go, rdy, sel_b;
    logic [31:0] saddr;

    logic        start_a, cv_a, busy_a, done_a, err_a;
    logic [7:0]  cd_a;
    logic [31:0] ma_a, rd_a;
    logic        start_b, cv_b, busy_b, done_b, err_b;
    logic [7:0]  cd_b;
    logic [31:0] ma_b, rd_b;

    logic [31:0] mem [logic [31:0]];
    int          mem_gen = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    always @(ma_a or mem_gen) rd_a = rd(ma_a);
    always @(ma_b or mem_gen) rd_b = rd(ma_b);

    assign start_a = go & ~sel_b;
    assign start_b = go & sel_b;

    print_string_unit dut_a (
        .clk(clk), .reset(reset), .start(start_a), .start_addr(saddr),
        .mem_addr(ma_a), .mem_read_data(rd_a), .char_valid(cv_a), .char_data(cd_a),
        .char_ready(rdy), .busy(busy_a), .done(done_a), .error(err_a)
    );

    print_string_unit #(.MAX_WORDS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .start_addr(saddr),
        .mem_addr(ma_b), .mem_read_data(rd_b), .char_valid(cv_b), .char_data(cd_b),
        .char_ready(rdy), .busy(busy_b), .done(done_b), .error(err_b)
    );

    logic        cv, busy, done, err;
    logic [7:0]  cd;
    logic [31:0] ma;
    always_comb begin
        cv   = sel_b ? cv_b   : cv_a;
        cd   = sel_b ? cd_b   : cd_a;
        busy = sel_b ? busy_b : busy_a;
        done = sel_b ? done_b : done_a;
        err  = sel_b ? err_b  : err_a;
        ma   = sel_b ? ma_b   : ma_a;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [31:0] addr_q[$];

    // Reference: follow the string rules directly; cycle count assumes char_ready held high
    // (one cycle per fetch, one per byte, one for the NUL/fault decision, one terminal cycle).
    task automatic model(input logic [31:0] a0, input int maxw, output bit is_err, output int cyc);
        logic [31:0] a;
        logic [31:0] w;
        int n;
        a = a0;
        n = 0;
        exp_q.delete();
        forever begin
            if (a < MEM_LO_ADDR || a > MEM_HI_ADDR || n == maxw) begin
                is_err = 1'b1;
                cyc = n + exp_q.size() + 2;
                return;
            end
            w = rd(a);
            n++;
            for (int i = 3; i >= 0; i--) begin
                if (w[8*i +: 8] == 8'h00) begin
                    is_err = 1'b0;
                    cyc = n + exp_q.size() + 2;
                    return;
                end
                exp_q.push_back(w[8*i +: 8]);
            end
            a = a - 32'd1;
        end
    endtask

    // rmode: 0 ready always, 1 random ready, 2 hold ready low 5 cycles on byte bp_idx.
    task automatic run(input logic [31:0] a, input int rmode, input int bp_idx, input int ign_cyc,
                       output bit got_done, output bit got_err, output int cyc,
                       output bit viol, output bit busy_after);
        bit pv;
        logic [7:0] pd;
        int bp;
        got_q.delete();
        addr_q.delete();
        viol = 0; got_done = 0; got_err = 0; cyc = 0; pv = 0; pd = '0; bp = 0;
        @(negedge clk);
        saddr = a; go = 1'b1; rdy = 1'b0;
        @(posedge clk);
        #1 go = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            @(negedge clk);
            go = (k == ign_cyc);
            if (busy && (addr_q.size() == 0 || addr_q[$] !== ma)) addr_q.push_back(ma);
            if (pv && (!cv || cd !== pd)) viol = 1;
            case (rmode)
                0: rdy = 1'b1;
                1: rdy = 1'($urandom_range(0, 1));
                default: begin
                    rdy = !(cv && got_q.size() == bp_idx && bp < 5);
                    if (!rdy) bp++;
                end
            endcase
            if (cv && rdy) got_q.push_back(cd);
            pv = cv && !rdy;
            pd = cd;
            if (done || err) begin
                got_done = done; got_err = err; cyc = k;
                break;
            end
        end
        go = 1'b0; rdy = 1'b0;
        if (cyc == 0) chk("terminate_timeout", 0, 1);
        @(negedge clk);
        busy_after = busy;
        chk("pulse_one_cycle", {done, err}, 2'b00);
    endtask

    task automatic chk_string(input string name);
        bit eq;
        eq = (got_q.size() == exp_q.size());
        if (eq) foreach (got_q[i]) if (got_q[i] !== exp_q[i]) eq = 0;
        checks++;
        if (!eq) begin
            errors++;
            $display("FAIL %s: got %0d bytes %p, expected %0d bytes %p",
                     name, got_q.size(), got_q, exp_q.size(), exp_q);
        end
    endtask

    task automatic load3(input logic [31:0] a, input logic [31:0] w0, w1, w2);
        mem.delete();
        mem[a] = w0; mem[a - 32'd1] = w1; mem[a - 32'd2] = w2;
        mem_gen++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_addr"}, ma_a, 32'h0);
        chk({tag, "_char_valid"}, cv_a, 1'b0);
        chk({tag, "_char_data"}, cd_a, 8'h0);
        chk({tag, "_busy"}, busy_a, 1'b0);
        chk({tag, "_done"}, done_a, 1'b0);
        chk({tag, "_error"}, err_a, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] w0, w1, w2;
        bit          use_b;
        logic [95:0] exp_s;
        int          exp_len;
        bit          exp_err;
        int          exp_cyc;
    } vec_t;

    vec_t tbl[5];

    initial begin
        bit d, e, v, ba, m_err;
        int c, m_cyc, cnt, rmode;
        logic [31:0] a;

        tbl[0] = '{32'h7FFFFFF0, 32'h68656c6c, 32'h6f20776f, 32'h726c6400, 1'b0, "hello world", 11, 1'b0, 16};
        tbl[1] = '{32'h7FFFFFFF, 32'h00414243, 32'h0, 32'h0, 1'b0, 96'h0, 0, 1'b0, 3};
        tbl[2] = '{32'h00000000, 32'h12345678, 32'h41414141, 32'h0, 1'b0, 96'h0, 0, 1'b1, 2};
        tbl[3] = '{32'h7FF00000, 32'h41424344, 32'h45464748, 32'h0, 1'b0, "ABCD", 4, 1'b1, 7};
        tbl[4] = '{32'h7FFFFFF0, 32'h41414141, 32'h41414141, 32'h41414141, 1'b1, "AAAAAAAA", 8, 1'b1, 12};

        go = 0; rdy = 0; sel_b = 0; saddr = '0; reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        chk("reset_b_busy", {busy_b, cv_b, done_b, err_b}, 4'b0);
        reset = 1'b0;

        // Directed table.
        foreach (tbl[i]) begin
            sel_b = tbl[i].use_b;
            load3(tbl[i].addr, tbl[i].w0, tbl[i].w1, tbl[i].w2);
            exp_q.delete();
            for (int j = 0; j < tbl[i].exp_len; j++)
                exp_q.push_back(tbl[i].exp_s[8*(tbl[i].exp_len-1-j) +: 8]);
            run(tbl[i].addr, 0, 0, 0, d, e, c, v, ba);
            chk_string($sformatf("vec%0d_string", i));
            chk($sformatf("vec%0d_outcome", i), {d, e}, {!tbl[i].exp_err, tbl[i].exp_err});
            chk($sformatf("vec%0d_cycles", i), c, tbl[i].exp_cyc);
            chk($sformatf("vec%0d_busy_after", i), ba, 1'b0);
            if (i == 0) begin
                chk("hello_addr_count", addr_q.size(), 3);
                if (addr_q.size() == 3)
                    chk("hello_addr_seq", {addr_q[0], addr_q[1], addr_q[2]},
                        {32'h7FFFFFF0, 32'h7FFFFFEF, 32'h7FFFFFEE});
            end
        end
        sel_b = 0;

        // Backpressure on 'o' (byte index 4): five extra cycles, data held.
        load3(32'h7FFFFFF0, 32'h68656c6c, 32'h6f20776f, 32'h726c6400);
        model(32'h7FFFFFF0, 256, m_err, m_cyc);
        run(32'h7FFFFFF0, 2, 4, 0, d, e, c, v, ba);
        chk_string("bp_string");
        chk("bp_held_stable", v, 1'b0);
        chk("bp_outcome", {d, e}, 2'b10);
        chk("bp_cycles", c, m_cyc + 5);

        // Reset in the middle of the string, then a clean rerun with a stray start while busy.
        @(negedge clk);
        saddr = 32'h7FFFFFF0; go = 1'b1; rdy = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100 && cnt < 6; k++) begin
            @(negedge clk);
            if (cv_a && rdy) cnt++;
        end
        chk("midreset_reached_byte6", cnt, 6);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_outputs("midreset");
        reset = 1'b0; rdy = 1'b0;
        run(32'h7FFFFFF0, 0, 0, 4, d, e, c, v, ba);
        chk_string("rerun_string");
        chk("rerun_outcome", {d, e}, 2'b10);
        chk("rerun_cycles", c, m_cyc);
        chk("rerun_start_ignored", ba, 1'b0);

        // Randomized strings near both ends of the window, against the reference model.
        for (int it = 0; it < 40; it++) begin
            sel_b = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: a = MEM_HI_ADDR - 32'($urandom_range(0, 3));
                1: a = MEM_LO_ADDR + 32'($urandom_range(0, 3));
                2: a = MEM_HI_ADDR + 32'($urandom_range(1, 2));
                default: a = MEM_HI_ADDR - 32'($urandom_range(4, 1000));
            endcase
            mem.delete();
            for (int j = 0; j < 6; j++) begin
                logic [31:0] w;
                for (int b = 0; b < 4; b++)
                    w[8*b +: 8] = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                mem[a - 32'(j)] = w;
            end
            mem_gen++;
            model(a, sel_b ? 2 : 256, m_err, m_cyc);
            rmode = it % 2;
            run(a, rmode, 0, 0, d, e, c, v, ba);
            chk_string($sformatf("rand%0d_string", it));
            chk($sformatf("rand%0d_outcome", it), {d, e}, {!m_err, m_err});
            chk($sformatf("rand%0d_held", it), v, 1'b0);
            if (rmode == 0) chk($sformatf("rand%0d_cycles", it), c, m_cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
